// File: rtl/inst_fetch.sv
// inst_fetch -- instruction fetch stage.
//
// Keeps the program counter, issues word reads to instruction memory over a
// valid/ready request channel (responses return in order), and buffers the
// returned words in a small FIFO. The decode stage sees {instruction, PC} pairs.
// A redirect from execute flushes the buffer, and responses still in flight for
// the old stream are counted so that they can be discarded when they arrive.
//
// Parameters:
//   RESET_PC    PC of the first fetch after reset
//   FIFO_DEPTH  buffer entries (power of two, >= 2); also the maximum number of
//               outstanding requests
//
// Ports:
//   clk, reset_n                   rising-edge clock, async active-low reset
//   mem_req_valid/ready/addr       fetch request channel (word address)
//   mem_rsp_valid/data             in-order read responses
//   out_valid/ready/inst/pc        buffer head towards decode
//   redirect_valid/redirect_pc     single-cycle branch/jump redirect
//   misaligned                     fetch halted on a misaligned redirect
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN  when defined, a redirect to a non-word-aligned PC
//                            halts fetch and raises misaligned until the next
//                            aligned redirect. When undefined, redirect_pc[1:0]
//                            are ignored and misaligned is tied low.

module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        misaligned
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;
  // Stale responses can pile up across back-to-back redirects, so the drop
  // counter is wider than the outstanding counter.
  localparam int DW = 8;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] drop;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic          halted;

  logic          pop;
  logic          req_fire;
  logic          rsp_live;
  logic          rsp_stale;
  logic [31:0]   rsp_pc;
  logic [SW-1:0] in_flight;

  assign pop       = out_valid && out_ready;
  assign req_fire  = mem_req_valid && mem_req_ready;
  assign rsp_live  = mem_rsp_valid && (drop == '0);
  assign rsp_stale = mem_rsp_valid && (drop != '0);

  // Live requests since the last redirect are consecutive words, so the oldest
  // one sits outstanding*4 bytes behind the next fetch address.
  assign rsp_pc = fetch_pc - 32'({outstanding, 2'b00});

  // Credit counts the head being popped this cycle as already free; without
  // that a two-entry buffer could only sustain every other cycle. The pop does
  // not depend on the memory handshake, so a request raised on its credit is
  // still covered next cycle and is never withdrawn.
  assign in_flight = SW'(fifo_count) + SW'(outstanding) - SW'(pop);

  assign mem_req_valid = reset_n && !redirect_valid && !halted &&
                         (in_flight < SW'(FIFO_DEPTH));
  assign mem_req_addr  = fetch_pc;

  assign out_valid = (fifo_count != '0);
  assign out_inst  = fifo_inst[rd_ptr];
  assign out_pc    = fifo_pc[rd_ptr];

  // Main fetch state: PC, request/drop accounting and the instruction buffer.
  // A redirect overrides everything else in its cycle: the buffer is emptied,
  // every live request becomes a response to drop (less the one arriving now,
  // which is itself discarded), and fetch restarts at the new PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      fifo_count  <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      fifo_count  <= '0;
      outstanding <= '0;
      drop        <= drop + DW'(outstanding) - DW'(mem_rsp_valid);
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_live);
      if (rsp_stale) begin
        drop <= drop - DW'(1);
      end
      if (rsp_live) begin
        fifo_inst[wr_ptr] <= mem_rsp_data;
        fifo_pc[wr_ptr]   <= rsp_pc;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count <= fifo_count + CW'(rsp_live) - CW'(pop);
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // Halt flag: set by a misaligned redirect, cleared by the next aligned one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halted <= 1'b0;
    end else if (redirect_valid) begin
      halted <= |redirect_pc[1:0];
    end
  end

  assign misaligned = halted;
`else
  logic unused_redirect_lsbs;

  assign halted               = 1'b0;
  assign misaligned           = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

endmodule
